tile_resolve: RTL and testbench
===============================

Name: tile_resolve

Overview:
- Downstream drain stage of the tile buffer. After rasterization of a tile completes, it reads the tile back as 2x2 quads and converts each pixel's 48-bit colour (16 bits per channel) to ARGB8888.
- Emits the pixels in raster-scanline order as 128-bit stream beats, 4 pixels per beat, to the framebuffer AXI writer.
- Absorbs the quad-to-scanline reordering with a one-row line buffer.

Parameters:
POS_ADDRW, 8, tile-buffer x/y address width
TILE_WIDTH, 128, pixels per tile row; multiple of 4
TILE_HEIGHT, 128, rows per tile; even
FIFO_DEPTH, 4, output FIFO entries (128b + last + user); power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_start  in  1  pulse: begin resolving current tile
o_busy  out  1  high from accepted start until done
o_done  out  1  1-cycle pulse once the last beat has been accepted downstream
i_tb_ready  in  1  tile buffer ready (not clearing)
o_rd_x  out  POS_ADDRW  quad read x (even)
o_rd_y  out  POS_ADDRW  quad read y (even)
o_rd_valid  out  1  quad read request
i_rd_data  in  72 x4  quad data: [0]=(x,y) [1]=(x+1,y) [2]=(x,y+1) [3]=(x+1,y+1); bits [71:24] colour {R16,G16,B16}, [23:0] depth (ignored)
i_rd_valid  in  1  quad data valid, fixed 1 cycle after request
m_axis_tdata  out  128  4 pixels; pixel x at [31:0], x+3 at [127:96]
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of a tile row
m_axis_tuser  out  1  first beat of tile

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, all counters 0.
- Pixel conversion (no optional feature): word = {8'hFF, R[15:8], G[15:8], B[15:8]}.
- States and transitions:
  - IDLE: i_start -> WAIT_TB and o_busy=1. i_start is ignored whenever o_busy=1.
  - WAIT_TB: waits for i_tb_ready=1, then -> READ with k=0, p=0.
  - READ: handles row pair p (rows 2p, 2p+1).
    - For each beat index k = 0..TILE_WIDTH/4-1, issues quads (4k, 2p) and then (4k+2, 2p) on consecutive issue cycles.
    - When the second quad returns: beat A = {q1[1], q1[0], q0[1], q0[0]} is pushed to the FIFO; beat B = {q1[3], q1[2], q0[3], q0[2]} is written to line buffer entry k.
    - After the last k, and once the final return has been processed, -> LINE.
  - LINE: streams line buffer entries 0..TILE_WIDTH/4-1 (1-cycle read latency) into the FIFO. Then p++ -> READ, or -> FLUSH if p was TILE_HEIGHT/2-1.
  - FLUSH: when the FIFO is empty, o_done=1 for one cycle, o_busy=0, -> IDLE.
- Credit rule: a quad pair or line-buffer read is issued only if FIFO count + beats in flight < FIFO_DEPTH. The FIFO can never overflow; tile-buffer data is never dropped.
- Reads are issued only while i_tb_ready=1; the issue sequence stalls (holds k and the pending pair) while it is low.
- A pair is issued atomically: the second quad is issued the cycle after the first unless i_tb_ready drops. If it drops, the second quad waits and the first quad's data stays held.
- Stream rules:
  - tvalid is held until accepted. tdata/tlast/tuser stay stable while tvalid=1 and tready=0.
  - tlast on beat TILE_WIDTH/4-1 of every row.
  - tuser only on beat 0 of row 0.
  - Total beats per tile = TILE_HEIGHT*TILE_WIDTH/4 (4096 by default).
- Throughput with tready=1: READ yields 1 beat per 2 cycles; LINE yields 1 beat per cycle.
- Line buffer: TILE_WIDTH/4 x 128b in distributed RAM. LINE finishes reading all entries before READ overwrites any of them.
- rst mid-tile: immediate return to IDLE. FIFO is flushed, tvalid=0, o_busy=0, no o_done. In-flight tile-buffer returns are discarded.
- Counter widths: k is $clog2(TILE_WIDTH/4), p is $clog2(TILE_HEIGHT/2). o_rd_x/o_rd_y are zero-extended to POS_ADDRW.

Optional Feature:
- Macro RESOLVE_ROUND_EN.
- Defined: each channel = min(255, (c16 + 16'h0080) >> 8), computed in 17 bits and saturated.
- Undefined: truncation, c16[15:8].
- Adds no latency in either mode.

Test Plan:
- Tile filled with colour 48'h1234_5678_9ABC, tready=1 -> 4096 beats, every pixel 32'hFF12569A, tlast on every 32nd beat, tuser on beat 0 only, o_done 1 cycle after last handshake.
- Pixel (x,y) colour R=x<<8, G=y<<8, B=0 -> beat n carries pixels x=4*(n%32)..+3 of row y=n/32 in ascending lanes; rows 2p+1 appear after rows 2p.
- Random tready (~30% duty) -> identical beat sequence to the tready=1 run; data stable while stalled; o_rd_valid never issues beyond credit.
- i_tb_ready low for 10 cycles during READ at k=5 -> stall, no lost or duplicated quads; output matches reference. A second i_start while busy is ignored.
- rst asserted on beat 1000 -> next cycle tvalid=0, o_busy=0; a fresh i_start then yields a full correct 4096-beat tile.
- RESOLVE_ROUND_EN defined, R=16'h12FF, G=16'hFF80, B=16'h007F -> pixel 32'hFF13FF00; undefined -> 32'hFF12FF00.

Source files
------------

// File: rtl/tile_resolve.sv
// tile_resolve: tile-buffer quad drain to ARGB8888 raster stream; RESOLVE_ROUND_EN selects rounding instead of truncation
module tile_resolve #(
  parameter int POS_ADDRW   = 8,
  parameter int TILE_WIDTH  = 128,
  parameter int TILE_HEIGHT = 128,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_tb_ready,
  output logic [POS_ADDRW-1:0] o_rd_x,
  output logic [POS_ADDRW-1:0] o_rd_y,
  output logic                 o_rd_valid,
  input  logic [3:0][71:0]     i_rd_data,
  input  logic                 i_rd_valid,
  output logic [127:0]         m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser
);
  localparam int NB = TILE_WIDTH / 4;
  localparam int NP = TILE_HEIGHT / 2;
  localparam int KW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = NP > 1 ? $clog2(NP) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_READ = 3'd2, S_LINE = 3'd3, S_FLUSH = 3'd4;

  function automatic logic [7:0] ch(input logic [15:0] c);
`ifdef RESOLVE_ROUND_EN
    logic [16:0] s;
    s = {1'b0, c} + 17'h00080;
    return s[16] ? 8'hFF : s[15:8];
`else
    return c[15:8];
`endif
  endfunction

  function automatic logic [31:0] px(input logic [71:0] d);
    return {8'hFF, ch(d[71:56]), ch(d[55:40]), ch(d[39:24])};
  endfunction

  logic [2:0] state_q, state_d;
  logic [KW-1:0] k_q, rk_q, lk_q;
  logic [PW-1:0] p_q;
  logic half_q, rhalf_q, iss_done_q, lb_v_q, lb_last_q;
  logic [63:0] q0a_q, q0b_q;
  logic [127:0] lb_dat_q;
  logic [127:0] lb_q [NB];
  logic [129:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, inf_q;
  logic [CW:0] occ;
  logic credit, rd_issue, lb_issue, ret, push_a, push, pop, k_last, rk_last, lk_last;
  logic [129:0] push_dat;
  logic unused_bits;

  assign unused_bits = ^i_rd_data;
  assign occ = {1'b0, cnt_q} + {1'b0, inf_q};
  assign credit = occ < (CW+1)'(FIFO_DEPTH);
  assign k_last = k_q == KW'(NB-1);
  assign rk_last = rk_q == KW'(NB-1);
  assign lk_last = lk_q == KW'(NB-1);
  assign rd_issue = state_q == S_READ && i_tb_ready && (half_q || (!iss_done_q && credit));
  assign lb_issue = state_q == S_LINE && credit && !(lb_v_q && lb_last_q);
  assign ret = i_rd_valid && state_q == S_READ;
  assign push_a = ret && rhalf_q;
  assign push = push_a || lb_v_q;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign push_dat = push_a ? {rk_q == '0 && p_q == '0, rk_last, px(i_rd_data[1]), px(i_rd_data[0]), q0a_q}
                           : {1'b0, lb_last_q, lb_dat_q};

  assign o_busy = state_q != S_IDLE;
  assign o_done = state_q == S_FLUSH && cnt_q == '0;
  assign o_rd_valid = rd_issue;
  assign o_rd_x = POS_ADDRW'({k_q, half_q, 1'b0});
  assign o_rd_y = POS_ADDRW'({p_q, 1'b0});
  assign m_axis_tvalid = cnt_q != '0;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem_q[rp_q] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = i_start ? S_WAIT : S_IDLE;
      S_WAIT:  state_d = i_tb_ready ? S_READ : S_WAIT;
      S_READ:  state_d = push_a && rk_last ? S_LINE : S_READ;
      S_LINE:  state_d = !(lb_v_q && lb_last_q) ? S_LINE : p_q == PW'(NP-1) ? S_FLUSH : S_READ;
      S_FLUSH: state_d = cnt_q == '0 ? S_IDLE : S_FLUSH;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      rk_q <= '0;
      lk_q <= '0;
      p_q <= '0;
      half_q <= 1'b0;
      rhalf_q <= 1'b0;
      iss_done_q <= 1'b0;
      lb_v_q <= 1'b0;
      lb_last_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      inf_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT) begin
        k_q <= '0;
        rk_q <= '0;
        lk_q <= '0;
        p_q <= '0;
        half_q <= 1'b0;
        rhalf_q <= 1'b0;
        iss_done_q <= 1'b0;
      end
      if (rd_issue) begin
        half_q <= !half_q;
        if (half_q) k_q <= k_last ? '0 : k_q + 1'b1;
        if (half_q && k_last) iss_done_q <= 1'b1;
      end
      if (ret) rhalf_q <= !rhalf_q;
      if (push_a) rk_q <= rk_last ? '0 : rk_q + 1'b1;
      if (lb_issue) lk_q <= lk_last ? '0 : lk_q + 1'b1;
      lb_v_q <= lb_issue;
      lb_last_q <= lb_issue && lk_last;
      if (state_q == S_LINE && state_d == S_READ) begin
        p_q <= p_q + 1'b1;
        iss_done_q <= 1'b0;
      end
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      inf_q <= inf_q + CW'(rd_issue && !half_q) + CW'(lb_issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (ret && !rhalf_q) begin
      q0a_q <= {px(i_rd_data[1]), px(i_rd_data[0])};
      q0b_q <= {px(i_rd_data[3]), px(i_rd_data[2])};
    end
    if (push_a) lb_q[rk_q] <= {px(i_rd_data[3]), px(i_rd_data[2]), q0b_q};
    if (lb_issue) lb_dat_q <= lb_q[lk_q];
    if (push) mem_q[wp_q] <= push_dat;
  end
endmodule

// File: tb/tb_tile_resolve.sv
// tb_tile_resolve: scoreboard bench for tile_resolve with a fixed-latency tile-buffer model
module tb_tile_resolve;
  localparam int W = 128, H = 128, NB = W / 4;
  logic clk = 0, rst = 1, i_start = 0, i_tb_ready = 1, i_rd_valid = 0, m_axis_tready = 0;
  logic [3:0][71:0] i_rd_data = '0;
  logic o_busy, o_done, o_rd_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [7:0] o_rd_x, o_rd_y;
  logic [127:0] m_axis_tdata;
  int n_cmp = 0, n_bad = 0, mode = 0, cyc = 0, last_hs = 0, acc = 0, dones = 0;
  bit rnd = 0, tr_off = 1;
  logic [129:0] exp_q [$];

  always #5 clk = ~clk;

  tile_resolve dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .i_tb_ready(i_tb_ready), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .o_rd_valid(o_rd_valid),
    .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  function automatic logic [47:0] col(int m, int x, int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return m == 0 ? 48'h1234_5678_9ABC : m == 1 ? {xb, 8'h00, yb, 8'h00, 16'h0000} : 48'h12FF_FF80_007F;
  endfunction

  function automatic logic [31:0] epx(int m, int x, int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
`ifdef RESOLVE_ROUND_EN
    return m == 0 ? 32'hFF12569A : m == 1 ? {8'hFF, xb, yb, 8'h00} : 32'hFF13FF00;
`else
    return m == 0 ? 32'hFF12569A : m == 1 ? {8'hFF, xb, yb, 8'h00} : 32'hFF12FF00;
`endif
  endfunction

  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_tile(input int m);
    for (int y = 0; y < H; y++)
      for (int n = 0; n < NB; n++)
        exp_q.push_back({y == 0 && n == 0, n == NB - 1, epx(m, 4*n+3, y), epx(m, 4*n+2, y), epx(m, 4*n+1, y), epx(m, 4*n, y)});
  endtask

  task automatic start_pulse();
    tick();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    if (i == 30000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no o_done want o_done within 30000 cycles", nm);
    end
    @(negedge clk);
    chk({nm, "_busy_clear"}, o_busy, 0);
    chk({nm, "_beats"}, acc, 4096);
    chk({nm, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_tile(input string nm, input int m);
    mode = m;
    acc = 0;
    push_tile(m);
    start_pulse();
    @(negedge clk);
    chk({nm, "_busy_set"}, o_busy, 1);
    wait_done(nm);
  endtask

  // Tile buffer: answers every sampled request with quad data one cycle later
  always begin
    logic req;
    int qx, qy;
    @(negedge clk);
    req = o_rd_valid;
    qx = int'(o_rd_x);
    qy = int'(o_rd_y);
    @(posedge clk);
    #1;
    i_rd_valid = req;
    for (int j = 0; j < 4; j++)
      i_rd_data[j] = {col(mode, qx + j % 2, qy + j / 2), 8'(qx), 8'(qy), 8'h5A};
  end

  always begin
    @(posedge clk);
    #1;
    m_axis_tready = tr_off ? 1'b0 : rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always begin
    logic [129:0] beat, held;
    bit stall;
    @(negedge clk);
    cyc++;
    beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (rst) stall = 0;
    else begin
      if (stall) chk("stall_hold", {m_axis_tvalid, beat}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got %h want no beat", beat);
        end else chk($sformatf("beat%0d", acc), beat, exp_q.pop_front());
        acc++;
        last_hs = cyc;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held = beat;
      if (o_done) begin
        dones++;
        chk("done_latency", cyc - last_hs, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1);
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {o_busy, o_done, o_rd_valid, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, o_rd_x, o_rd_y}, 0);
    tick();
    rst = 0;
    tr_off = 0;
    run_tile("const", 0);
    run_tile("grad", 1);
    rnd = 1;
    run_tile("rnd", 1);
    rnd = 0;
    // i_tb_ready drops right after the first quad of beat 5 is issued
    mode = 1;
    acc = 0;
    push_tile(1);
    start_pulse();
    for (i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (o_rd_valid && o_rd_x == 8'd20 && o_rd_y == 8'd0) break;
    end
    chk("k5_reached", i < 20000, 1);
    tick();
    i_tb_ready = 0;
    repeat (5) tick();
    @(negedge clk);
    chk("no_issue_stalled", o_rd_valid, 0);
    repeat (5) tick();
    i_tb_ready = 1;
    repeat (30) tick();
    start_pulse();
    wait_done("stall");
    repeat (20) @(negedge clk);
    chk("second_start_ignored", {o_busy, m_axis_tvalid}, 0);
    // reset in the middle of a tile
    mode = 1;
    acc = 0;
    push_tile(1);
    start_pulse();
    for (i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (acc >= 1000) break;
    end
    chk("reached_beat_1000", i < 20000, 1);
    tr_off = 1;
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    chk("mid_reset_outputs", {m_axis_tvalid, o_busy, o_done}, 0);
    exp_q.delete();
    tick();
    rst = 0;
    tr_off = 0;
    chk("no_done_on_reset", dones, 4);
    run_tile("after_rst", 1);
    run_tile("conv", 2);
    chk("done_count", dones, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
